ext_bus_if: RTL

EXT_BUS_IF -- requirements
Module: ext_bus_if

---
 rtl/ext_bus_if_pkg.sv | 24 ++
 rtl/ext_bus_if_if.sv | 26 ++
 rtl/ext_bus_if_strobe_edge.sv | 24 ++
 rtl/ext_bus_if.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_if_pkg.sv
// Shared MCU51 definitions for the external bus interface: FSM state
// encodings, the port idle drive value and a strobe-conflict helper.
package ext_bus_if_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    HOLD    = 3'd2,
    FLOAT   = 3'd3,
    CODE_RD = 3'd4,
    X_RD    = 3'd5,
    X_WR    = 3'd6,
    WR_HOLD = 3'd7
  } bus_state_t;

  // Value a port pin register holds when it is not driving anything useful.
  localparam logic [7:0] PORT_IDLE = 8'hFF;

  // True when two or more of the low-active strobes are asserted at once.
  function automatic logic multi_low(input logic psen, input logic rd, input logic wr);
    return (!psen && !rd) || (!psen && !wr) || (!rd && !wr);
  endfunction

endpackage

// File: rtl/ext_bus_if_if.sv
// Pin-level bus bundle between the CU-side bus controller and the port pins:
// control strobes, P0 multiplexed address/data and P2 high address.
interface ext_bus_if_if;

  logic       ALE;
  logic       PSEN;
  logic       RD;
  logic       WR;
  logic [7:0] p0_in;
  logic [7:0] p0_out;
  logic       p0_oe;
  logic [7:0] p2_out;

  // Side that issues strobes and observes the port drive.
  modport master (
    output ALE, PSEN, RD, WR, p0_in,
    input  p0_out, p0_oe, p2_out
  );

  // Side that sequences the port pins in response to the strobes.
  modport slave (
    input  ALE, PSEN, RD, WR, p0_in,
    output p0_out, p0_oe, p2_out
  );

endinterface

// File: rtl/ext_bus_if_strobe_edge.sv
// Edge detector for one control strobe: keeps the value sampled on the
// previous rising clock edge and flags rising and falling transitions.
// The previous value resets to 0, so a strobe already low when reset
// releases does not look like a fresh assertion.
module strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;

  // Remember last sampled level of the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/ext_bus_if.sv
// External bus interface of the MCU51: latches code/XDATA addresses on ALE,
// drives P0/P2, captures read data on the trailing edge of PSEN/RD and
// drives write data for the WR strobe. Protocol conflicts set a sticky flag.
module ext_bus_if
  import ext_bus_if_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ext_bus_if_if.slave        bus,
  input  logic [15:0]        pc,
  input  logic [15:0]        xaddr,
  input  logic               xacc,
  input  logic               xacc8,
  input  logic [7:0]         p2_sfr,
  input  logic [7:0]         wdata,
  output logic [7:0]         code_byte,
  output logic [7:0]         xdata_byte,
  output logic               code_valid,
  output logic               xdata_valid,
  output logic               bus_err
);

  bus_state_t  state;
  logic [15:0] addr_q;
  logic        xacc_q;
  logic        xacc8_q;
  logic        xdone;
  logic        pend_psen;
  logic        pend_rd;
  logic        pend_wr;

  logic        ale_rise, ale_fall;
  logic        psen_rise, psen_fall;
  logic        rd_rise, rd_fall;
  logic        wr_rise, wr_fall;

  logic [15:0] addr_sel;
  logic [7:0]  p2_track;
  logic        req_psen, req_rd, req_wr;

  strobe_edge u_ale  (.clk(clk), .reset(reset), .d(bus.ALE),  .rise(ale_rise),  .fall(ale_fall));
  strobe_edge u_psen (.clk(clk), .reset(reset), .d(bus.PSEN), .rise(psen_rise), .fall(psen_fall));
  strobe_edge u_rd   (.clk(clk), .reset(reset), .d(bus.RD),   .rise(rd_rise),   .fall(rd_fall));
  strobe_edge u_wr   (.clk(clk), .reset(reset), .d(bus.WR),   .rise(wr_rise),   .fall(wr_fall));

  assign addr_sel = xacc ? xaddr : pc;

  // P2 shows the SFR for 8-bit MOVX and after a finished XDATA access,
  // otherwise the high byte of the latched address.
  assign p2_track = ((xacc_q && xacc8_q) || (xdone && state == IDLE)) ? p2_sfr : addr_q[15:8];

  // A strobe seen during HOLD is remembered and honoured once P0 floats.
  assign req_psen = pend_psen | ~bus.PSEN;
  assign req_rd   = pend_rd   | ~bus.RD;
  assign req_wr   = pend_wr   | ~bus.WR;

  // Bus cycle sequencer with registered port drives and capture outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bus.p0_oe   <= 1'b0;
      bus.p0_out  <= PORT_IDLE;
      bus.p2_out  <= PORT_IDLE;
      addr_q      <= 16'h0000;
      xacc_q      <= 1'b0;
      xacc8_q     <= 1'b0;
      xdone       <= 1'b0;
      pend_psen   <= 1'b0;
      pend_rd     <= 1'b0;
      pend_wr     <= 1'b0;
      code_byte   <= 8'h00;
      xdata_byte  <= 8'h00;
      code_valid  <= 1'b0;
      xdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      xdata_valid <= 1'b0;
      bus.p2_out  <= p2_track;
      if (multi_low(bus.PSEN, bus.RD, bus.WR)) bus_err <= 1'b1;

      if (ale_rise) begin
        // New address phase overrides whatever cycle was in flight.
        addr_q     <= addr_sel;
        xacc_q     <= xacc;
        xacc8_q    <= xacc8;
        xdone      <= 1'b0;
        pend_psen  <= 1'b0;
        pend_rd    <= 1'b0;
        pend_wr    <= 1'b0;
        state      <= ADDR;
        bus.p0_oe  <= 1'b1;
        bus.p0_out <= addr_sel[7:0];
        bus.p2_out <= (xacc && xacc8) ? p2_sfr : addr_sel[15:8];
      end else begin
        unique case (state)
          IDLE: begin
            // Only a fresh assertion starts a cycle, reusing the last address.
            if (psen_fall) begin
              state <= CODE_RD;
            end else if (rd_fall) begin
              state <= X_RD;
            end else if (wr_fall) begin
              state      <= X_WR;
              bus.p0_oe  <= 1'b1;
              bus.p0_out <= wdata;
            end
            if (psen_fall || rd_fall || wr_fall) begin
              xdone      <= 1'b0;
              bus.p2_out <= (xacc_q && xacc8_q) ? p2_sfr : addr_q[15:8];
            end
          end
          ADDR: begin
            if (ale_fall) state <= HOLD;
          end
          HOLD: begin
            pend_psen  <= ~bus.PSEN;
            pend_rd    <= ~bus.RD;
            pend_wr    <= ~bus.WR;
            state      <= FLOAT;
            bus.p0_oe  <= 1'b0;
            bus.p0_out <= PORT_IDLE;
          end
          FLOAT: begin
            pend_psen <= 1'b0;
            pend_rd   <= 1'b0;
            pend_wr   <= 1'b0;
            // A remembered strobe that is already released completes at once.
            if (req_psen) begin
              if (!bus.PSEN) begin
                state <= CODE_RD;
              end else begin
                code_byte  <= bus.p0_in;
                code_valid <= 1'b1;
                state      <= IDLE;
              end
            end else if (req_rd) begin
              if (!bus.RD) begin
                state <= X_RD;
              end else begin
                xdata_byte  <= bus.p0_in;
                xdata_valid <= 1'b1;
                xdone       <= 1'b1;
                bus.p2_out  <= p2_sfr;
                state       <= IDLE;
              end
            end else if (req_wr) begin
              bus.p0_oe  <= 1'b1;
              bus.p0_out <= wdata;
              state      <= bus.WR ? WR_HOLD : X_WR;
            end
          end
          CODE_RD: begin
            if (psen_rise) begin
              code_byte  <= bus.p0_in;
              code_valid <= 1'b1;
              state      <= IDLE;
            end
          end
          X_RD: begin
            if (rd_rise) begin
              xdata_byte  <= bus.p0_in;
              xdata_valid <= 1'b1;
              xdone       <= 1'b1;
              bus.p2_out  <= p2_sfr;
              state       <= IDLE;
            end
          end
          X_WR: begin
            if (wr_rise) state <= WR_HOLD;
          end
          WR_HOLD: begin
            bus.p0_oe  <= 1'b0;
            bus.p0_out <= PORT_IDLE;
            xdone      <= 1'b1;
            bus.p2_out <= p2_sfr;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
